regfile_mp: RTL
===============

Name: regfile_mp

Overview:
- Parametrised successor to the single-cycle core's 2-read/1-write register file.
- Configurable width, depth and read-port count; x0 hardwired to zero; optional write-to-read bypass.
- Post-reset clear state machine zeroes storage one entry per cycle, so the array maps to RAM-style storage without per-bit reset.
- Pending-write scoreboard (busy bits) lets the multi-cycle/pipelined datapath detect RAW hazards.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of architectural registers; power of two, >= 2. Derived AW = clog2(NREG).
- NRD, 2, number of independent read ports, >= 1.
- BYPASS, 1, 1 = read returns same-cycle write data on address match; 0 = read returns stored value only.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- ready, output, 1, 1 = clear complete, file usable.
- we, input, 1, write enable.
- wr_addr, input, AW, write address.
- wr_data, input, XLEN, write data.
- rs_addr, input, NRD*AW, read addresses; port k at bits [k*AW +: AW].
- rs_data, output, NRD*XLEN, read data; port k at bits [k*XLEN +: XLEN].
- rs_busy, output, NRD, port k's register has a pending write.
- issue_valid, input, 1, instruction issued that will write issue_rd.
- issue_rd, input, AW, destination of issued instruction.

Behaviour:
- Reset: asynchronous on rst_n=0, at any time including mid-clear or mid-operation.
  - Reset values: state=CLEAR, clr_idx=1, busy[all]=0, ready=0.
  - Array contents undefined until cleared.
- CLEAR state:
  - Each posedge writes 0 to entry clr_idx, then clr_idx++.
  - When clr_idx==NREG-1 is written, next state=RUN and ready=1.
  - ready therefore rises after exactly NREG-1 rising edges following rst_n deassertion (31 for NREG=32).
  - we and issue_valid are ignored; rs_data=0 and rs_busy=0 on all ports.
- RUN state: stays in RUN until reset. No other transitions.
- Write:
  - At posedge, if we=1 and wr_addr!=0, entry[wr_addr] <= wr_data.
  - Writes to address 0 are discarded.
- Read: combinational, zero latency, each port independent. Priority:
  - rs_addr==0 -> 0.
  - Else if BYPASS=1 and we=1 and wr_addr==rs_addr -> wr_data.
  - Else -> entry[rs_addr].
  - With BYPASS=0, written data is visible the cycle after the write edge.
- Scoreboard (RUN only), evaluated at posedge:
  - issue_valid=1 and issue_rd!=0 -> busy[issue_rd] <= 1.
  - we=1 and wr_addr!=0 -> busy[wr_addr] <= 0.
  - Set and clear of the same index in one cycle: set wins (a new producer supersedes the retiring one).
  - busy[0] is constant 0.
- rs_busy[k]:
  - Normally busy[rs_addr_k].
  - If BYPASS=1 and we=1 and wr_addr==rs_addr_k, forced to 0, because the data is being forwarded.
- Width rules:
  - No truncation; all addresses are full AW bits.
  - NREG power of two, so there are no out-of-range addresses.
- Concurrency: any number of read ports may address the same register; all return the identical value.

Test Plan:
- Reset release, NREG=32: count edges -> ready=0 for the first 30 edges, 1 after the 31st. Read of any register during clear returns 0; read after clear returns 0x00000000.
- Write x5=0xDEADBEEF with rs_addr port0=5 in the same cycle -> BYPASS=1: port0=0xDEADBEEF immediately. BYPASS=0: old value (0) that cycle, 0xDEADBEEF next cycle.
- Write x0=0x12345678, then read port0=0 and port1=0 -> both 0x00000000; busy[0] stays 0 after issue_rd=0.
- issue_valid with issue_rd=7, then we with wr_addr=7 three cycles later -> rs_busy=1 for addr 7 until the write cycle. During the write cycle rs_busy=0 when BYPASS=1, and 0 the cycle after in both modes.
- Same-cycle issue_rd=9 and we wr_addr=9 -> busy[9]=1 after the edge, and entry[9] holds the written data.
- Assert rst_n=0 mid-RUN after writing x3=0xA5A5A5A5 -> ready drops immediately (asynchronous). After re-clear, x3 reads 0 and all rs_busy=0.

Source files
------------

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with hardwired x0, optional
// write-to-read bypass, post-reset clear sequencer and pending-write busy bits.
module regfile_mp #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned NREG   = 32,
   parameter int unsigned NRD    = 2,
   parameter int unsigned BYPASS = 1
) (
   input  logic                            clk,
   input  logic                            rst_n,
   output logic                            ready,
   input  logic                            we,
   input  logic [$clog2(NREG)-1:0]         wr_addr,
   input  logic [XLEN-1:0]                 wr_data,
   input  logic [NRD*$clog2(NREG)-1:0]     rs_addr,
   output logic [NRD*XLEN-1:0]             rs_data,
   output logic [NRD-1:0]                  rs_busy,
   input  logic                            issue_valid,
   input  logic [$clog2(NREG)-1:0]         issue_rd
);

   localparam int unsigned AW = $clog2(NREG);

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic [AW-1:0]     clr_idx_q, clr_idx_d;
   logic              ready_q, ready_d;
   logic [NREG-1:0]   busy_q, busy_d;

   // Storage has no reset; the clear sequencer initialises it after rst_n.
   logic [XLEN-1:0]   mem_q [NREG];
   logic              mem_we;
   logic [AW-1:0]     mem_waddr;
   logic [XLEN-1:0]   mem_wdata;

   logic              wr_live;
   logic              issue_live;

   assign wr_live    = we && (wr_addr != '0);
   assign issue_live = issue_valid && (issue_rd != '0);

   // Next-state, clear sequencing, write port steering and scoreboard update.
   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      ready_d   = ready_q;
      busy_d    = busy_q;
      mem_we    = 1'b0;
      mem_waddr = wr_addr;
      mem_wdata = wr_data;

      case (state_q)
         ST_CLEAR: begin
            mem_we    = 1'b1;
            mem_waddr = clr_idx_q;
            mem_wdata = '0;
            clr_idx_d = clr_idx_q + AW'(1);
            if (clr_idx_q == AW'(NREG - 1)) begin
               state_d = ST_RUN;
               ready_d = 1'b1;
            end
         end
         ST_RUN: begin
            if (wr_live) begin
               mem_we          = 1'b1;
               busy_d[wr_addr] = 1'b0;
            end
            // A newly issued producer supersedes one retiring this cycle.
            if (issue_live) begin
               busy_d[issue_rd] = 1'b1;
            end
         end
         default: begin
            state_d = ST_CLEAR;
         end
      endcase

      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_CLEAR;
         clr_idx_q <= AW'(1);
         ready_q   <= 1'b0;
         busy_q    <= '0;
      end else begin
         state_q   <= state_d;
         clr_idx_q <= clr_idx_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   // Independent combinational read ports: x0, then bypass, then storage.
   always_comb begin
      logic [AW-1:0] addr;
      addr    = '0;
      rs_data = '0;
      rs_busy = '0;
      for (int unsigned k = 0; k < NRD; k++) begin
         addr = rs_addr[k*AW +: AW];
         if ((state_q == ST_RUN) && (addr != '0)) begin
            if ((BYPASS != 0) && wr_live && (wr_addr == addr)) begin
               rs_data[k*XLEN +: XLEN] = wr_data;
               rs_busy[k]              = 1'b0;
            end else begin
               rs_data[k*XLEN +: XLEN] = mem_q[addr];
               rs_busy[k]              = busy_q[addr];
            end
         end
      end
   end

   assign ready = ready_q;

endmodule
